fp_mul_pipe: RTL and testbench
==============================

Name: fp_mul_pipe

Overview:
Parametrised, fully pipelined IEEE-754-style floating-point multiplier. It is the successor to the single-shot multiply_32 and sits in the NLA datapath feeding the polynomial/approximation evaluators. Format width is configurable (FP32, BF16, FP16 via EXP_W/MAN_W). It accepts one operand pair per cycle, rounds to nearest-even, and provides valid/ready backpressure and exception flags.

Parameters:
EXP_W, 8, exponent field width (>=4)
MAN_W, 23, stored mantissa (fraction) width (>=3)
DATA_W, 1+EXP_W+MAN_W, derived operand/result width (localparam, not overridable)

Ports:
clk_i  in  1  clock, rising edge
rstn_i  in  1  reset, asynchronous, active-low
valid_i  in  1  operand pair valid
ready_o  out  1  block can accept operands this cycle
a_i  in  DATA_W  operand A
b_i  in  DATA_W  operand B
valid_o  out  1  result valid
ready_i  in  1  downstream accepts result
result_o  out  DATA_W  product
flags_o  out  4  {invalid, overflow, underflow, inexact}, aligned with result_o

Behaviour:
- Reset: valid_o=0, result_o=0, flags_o=0, all stage valid bits=0. Asserting rstn_i mid-operation discards all in-flight data; nothing emerges after release.
- Transfer: in on valid_i&&ready_o; out on valid_o&&ready_i.
- Pipeline: 3 stages, latency exactly 3 cycles from accept to valid_o with ready_i held high; throughput 1/cycle.
- Stall: advance = !valid_o || ready_i; ready_o = advance (combinational). When advance=0, every stage holds; result_o/flags_o stay stable while valid_o=1 and ready_i=0. Bubbles are not compressed.
- S1 (unpack): sign = sa^sb; classify each operand as ZERO, NORM, INF, QNAN or SNAN. exp==0 is ZERO, so subnormal inputs are flushed to zero (FTZ). Exponent sum ea+eb-BIAS is signed, EXP_W+2 bits wide, with BIAS=2^(EXP_W-1)-1. Special result is resolved here.
- S2: product of {1,ma}×{1,mb}, width 2*(MAN_W+1).
- S3 (normalise/round/pack):
  - Normalise: if product MSB=1, shift right 1 and exp+1.
  - Rounding bits: guard = next bit below the LSB; sticky = OR of the rest.
  - RNE: round up if guard&&(sticky||lsb).
  - A mantissa carry-out from rounding gives exp+1 and mantissa 0.
- Exceptions, in priority order:
  1. Any NaN input, or INF×ZERO → canonical qNaN (sign 0, exp all ones, fraction MSB 1, rest 0). invalid=1 for INF×ZERO or any SNAN input. A QNAN-only case sets no flags.
  2. INF×(NORM|INF) → signed infinity, no flags.
  3. ZERO×(NORM|ZERO) → signed zero, no flags.
  4. Final exp >= 2^EXP_W-1 → signed infinity, overflow=1, inexact=1.
  5. Final exp <= 0 → signed zero (FTZ output), underflow=1, inexact=1.
  6. Otherwise normal pack; inexact = guard|sticky.
- flags_o is 0 whenever valid_o=0.

Decomposition:
- Package fp_pkg holds:
  - fp_class_e enum (ZERO, NORM, INF, QNAN, SNAN)
  - fp_flags_t packed struct {invalid, overflow, underflow, inexact}
  - BIAS/QNAN constant functions of EXP_W/MAN_W
  - fp_classify function, reusable by a future fp_add_pipe
- One sub-module, fp_round_pack (S3 combinational: normalise, RNE, exception select, pack). It is parametrised identically.

Test Plan:
- FP32 1.0×1.0: 0x3F800000×0x3F800000 → 0x3F800000, flags 0, valid_o exactly 3 cycles after accept. Then 2.0×3.0: 0x40000000×0x40400000 → 0x40C00000.
- FP32 RNE/inexact: 0x3F800001×0x3F800001 → 0x3F800002, inexact=1. Also 0x2317A4DB×0 → 0x00000000, flags 0.
- FP32 exceptions:
  - 0x7F800000×0x00000000 → 0x7FC00000, invalid=1
  - 0x7F000000×0x40000000 → 0x7F800000, overflow|inexact
  - 0x00800000×0x3F000000 → 0x00000000, underflow|inexact
  - 0xFF800000×0x40000000 → 0xFF800000, flags 0
- Streaming/backpressure: 8 back-to-back pairs with ready_i low for cycles 4-7. ready_o drops; result_o is held stable; all 8 results arrive in order with none lost or duplicated.
- BF16 (EXP_W=8, MAN_W=7): 0x3F80×0x4040 → 0x4040. Also 0x4000×0x4040 → 0x40C0.
- Reset mid-flight: accept 2 pairs, pulse rstn_i low for 1 ns between edges. valid_o=0 immediately and stays 0 with valid_i low; the next accepted pair emerges correctly 3 cycles later.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared floating-point types and helpers for the NLA arithmetic pipes.
package fp_pkg;

  typedef enum logic [2:0] {
    FpZero,
    FpNorm,
    FpInf,
    FpQnan,
    FpSnan
  } fp_class_e;

  typedef struct packed {
    logic invalid;
    logic overflow;
    logic underflow;
    logic inexact;
  } fp_flags_t;

  function automatic int unsigned fp_bias(input int unsigned exp_w);
    return (32'd1 << (exp_w - 1)) - 32'd1;
  endfunction

  // Canonical quiet NaN: sign 0, exponent all ones, fraction MSB only.
  function automatic logic [63:0] fp_qnan(input int unsigned exp_w, input int unsigned man_w);
    logic [63:0] v;
    v = ((64'd1 << exp_w) - 64'd1) << man_w;
    v = v | (64'd1 << (man_w - 1));
    return v;
  endfunction

  // Subnormals (exp == 0) classify as zero: the datapath flushes them.
  function automatic fp_class_e fp_classify(input logic exp_zero, input logic exp_ones,
                                            input logic man_zero, input logic man_msb);
    if (exp_zero)      return FpZero;
    else if (!exp_ones) return FpNorm;
    else if (man_zero) return FpInf;
    else if (man_msb)  return FpQnan;
    else               return FpSnan;
  endfunction

endpackage

// File: rtl/fp_round_pack.sv
// Final multiplier stage: normalise, round-to-nearest-even, exception select, pack.
module fp_round_pack
  import fp_pkg::*;
#(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23,
  localparam int unsigned DATA_W = 1 + EXP_W + MAN_W,
  localparam int unsigned PW = 2 * (MAN_W + 1),
  localparam int unsigned SW = EXP_W + 2
) (
  input  logic                 sign,
  input  logic                 special,
  input  logic                 spec_invalid,
  input  logic [DATA_W-1:0]    spec_result,
  input  logic signed [SW-1:0] exp_in,
  input  logic [PW-1:0]        prod,
  output logic [DATA_W-1:0]    result,
  output fp_flags_t            flags
);

  localparam logic signed [SW-1:0] EXP_MAX  = SW'((1 << EXP_W) - 1);
  localparam logic signed [SW-1:0] EXP_ZERO = '0;

  logic [PW-1:0]        norm;
  logic [MAN_W-1:0]     frac;
  logic                 guard, sticky, round_up;
  logic [MAN_W:0]       frac_rnd;
  logic signed [SW-1:0] exp_norm, exp_fin;

  // Normalise so the hidden one sits at the product MSB, then round and classify.
  always_comb begin
    norm     = prod[PW-1] ? prod : (prod << 1);
    exp_norm = exp_in + $signed({{(SW-1){1'b0}}, prod[PW-1]});
    frac     = norm[PW-2 -: MAN_W];
    guard    = norm[PW-2-MAN_W];
    sticky   = |norm[PW-3-MAN_W:0];
    round_up = guard & (sticky | frac[0]);
    frac_rnd = {1'b0, frac} + {{MAN_W{1'b0}}, round_up};
    // Rounding carry-out leaves the fraction at zero and bumps the exponent.
    exp_fin  = exp_norm + $signed({{(SW-1){1'b0}}, frac_rnd[MAN_W]});
    result   = {sign, exp_fin[EXP_W-1:0], frac_rnd[MAN_W-1:0]};
    flags    = '0;
    if (special) begin
      result        = spec_result;
      flags.invalid = spec_invalid;
    end else if (exp_fin >= EXP_MAX) begin
      result         = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      flags.overflow = 1'b1;
      flags.inexact  = 1'b1;
    end else if (exp_fin <= EXP_ZERO) begin
      result          = {sign, {(DATA_W-1){1'b0}}};
      flags.underflow = 1'b1;
      flags.inexact   = 1'b1;
    end else begin
      flags.inexact = guard | sticky;
    end
  end

endmodule

// File: rtl/fp_mul_pipe.sv
// Three-stage pipelined floating-point multiplier with valid/ready flow control.
module fp_mul_pipe
  import fp_pkg::*;
#(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23,
  localparam int unsigned DATA_W = 1 + EXP_W + MAN_W
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [DATA_W-1:0] result_o,
  output logic [3:0]        flags_o
);

  localparam int unsigned PW = 2 * (MAN_W + 1);
  localparam int unsigned SW = EXP_W + 2;
  localparam int unsigned BIAS = fp_bias(EXP_W);
  localparam logic [DATA_W-1:0] QNAN = DATA_W'(fp_qnan(EXP_W, MAN_W));

  logic advance;
  assign advance = !valid_o || ready_i;
  assign ready_o = advance;

  // Stage 1 unpack
  logic              sa, sb, sign;
  logic [EXP_W-1:0]  ea, eb;
  logic [MAN_W-1:0]  ma, mb;
  fp_class_e         ca, cb;
  logic              any_nan, any_snan, inf_zero;
  logic              sp_d, sp_inv_d;
  logic [DATA_W-1:0] sp_res_d;
  logic signed [SW-1:0] esum_d;

  assign {sa, ea, ma} = a_i;
  assign {sb, eb, mb} = b_i;
  assign sign = sa ^ sb;

  // Classify operands and resolve NaN/Inf/zero results ahead of the datapath.
  always_comb begin
    ca       = fp_classify(ea == '0, &ea, ma == '0, ma[MAN_W-1]);
    cb       = fp_classify(eb == '0, &eb, mb == '0, mb[MAN_W-1]);
    any_nan  = (ca inside {FpQnan, FpSnan}) || (cb inside {FpQnan, FpSnan});
    any_snan = (ca == FpSnan) || (cb == FpSnan);
    inf_zero = (ca == FpInf && cb == FpZero) || (ca == FpZero && cb == FpInf);
    esum_d   = $signed({2'b00, ea}) + $signed({2'b00, eb}) - $signed(SW'(BIAS));
    sp_d     = 1'b0;
    sp_inv_d = 1'b0;
    sp_res_d = '0;
    if (any_nan || inf_zero) begin
      sp_d     = 1'b1;
      sp_res_d = QNAN;
      sp_inv_d = any_snan || inf_zero;
    end else if (ca == FpInf || cb == FpInf) begin
      sp_d     = 1'b1;
      sp_res_d = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (ca == FpZero || cb == FpZero) begin
      sp_d     = 1'b1;
      sp_res_d = {sign, {(DATA_W-1){1'b0}}};
    end
  end

  logic                 s1_valid, s1_sign, s1_special, s1_spec_inv;
  logic [DATA_W-1:0]    s1_spec_res;
  logic signed [SW-1:0] s1_exp;
  logic [MAN_W-1:0]     s1_ma, s1_mb;

  // Stage 1 register: unpacked operands and pre-resolved special result.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      s1_valid    <= 1'b0;
      s1_sign     <= 1'b0;
      s1_special  <= 1'b0;
      s1_spec_inv <= 1'b0;
      s1_spec_res <= '0;
      s1_exp      <= '0;
      s1_ma       <= '0;
      s1_mb       <= '0;
    end else if (advance) begin
      s1_valid    <= valid_i;
      s1_sign     <= sign;
      s1_special  <= sp_d;
      s1_spec_inv <= sp_inv_d;
      s1_spec_res <= sp_res_d;
      s1_exp      <= esum_d;
      s1_ma       <= ma;
      s1_mb       <= mb;
    end
  end

  logic                 s2_valid, s2_sign, s2_special, s2_spec_inv;
  logic [DATA_W-1:0]    s2_spec_res;
  logic signed [SW-1:0] s2_exp;
  logic [PW-1:0]        s2_prod;

  // Stage 2 register: full-width significand product.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      s2_valid    <= 1'b0;
      s2_sign     <= 1'b0;
      s2_special  <= 1'b0;
      s2_spec_inv <= 1'b0;
      s2_spec_res <= '0;
      s2_exp      <= '0;
      s2_prod     <= '0;
    end else if (advance) begin
      s2_valid    <= s1_valid;
      s2_sign     <= s1_sign;
      s2_special  <= s1_special;
      s2_spec_inv <= s1_spec_inv;
      s2_spec_res <= s1_spec_res;
      s2_exp      <= s1_exp;
      s2_prod     <= PW'({1'b1, s1_ma}) * PW'({1'b1, s1_mb});
    end
  end

  logic [DATA_W-1:0] rp_result;
  fp_flags_t         rp_flags;

  fp_round_pack #(
    .EXP_W(EXP_W),
    .MAN_W(MAN_W)
  ) u_round_pack (
    .sign        (s2_sign),
    .special     (s2_special),
    .spec_invalid(s2_spec_inv),
    .spec_result (s2_spec_res),
    .exp_in      (s2_exp),
    .prod        (s2_prod),
    .result      (rp_result),
    .flags       (rp_flags)
  );

  // Output register; bubbles carry zero result and flags.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      valid_o  <= 1'b0;
      result_o <= '0;
      flags_o  <= '0;
    end else if (advance) begin
      valid_o  <= s2_valid;
      result_o <= s2_valid ? rp_result : '0;
      flags_o  <= s2_valid ? rp_flags : 4'b0000;
    end
  end

endmodule

// File: tb/tb_fp_mul_pipe.sv
// Directed self-checking bench for fp_mul_pipe (FP32 and BF16 instances).
module tb_fp_mul_pipe;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;

  logic        v32 = 1'b0, r32 = 1'b1, vo32, ro32;
  logic [31:0] a32 = '0, b32 = '0, res32;
  logic [3:0]  fl32;

  logic        v16 = 1'b0, r16 = 1'b1, vo16, ro16;
  logic [15:0] a16 = '0, b16 = '0, res16;
  logic [3:0]  fl16;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fp_mul_pipe #(
    .EXP_W(8),
    .MAN_W(23)
  ) dut32 (
    .clk_i   (clk),
    .rstn_i  (rstn),
    .valid_i (v32),
    .ready_o (ro32),
    .a_i     (a32),
    .b_i     (b32),
    .valid_o (vo32),
    .ready_i (r32),
    .result_o(res32),
    .flags_o (fl32)
  );

  fp_mul_pipe #(
    .EXP_W(8),
    .MAN_W(7)
  ) dut16 (
    .clk_i   (clk),
    .rstn_i  (rstn),
    .valid_i (v16),
    .ready_o (ro16),
    .a_i     (a16),
    .b_i     (b16),
    .valid_o (vo16),
    .ready_i (r16),
    .result_o(res16),
    .flags_o (fl16)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // One isolated transaction; result must appear exactly three edges after accept.
  task automatic op(input bit bf, input logic [31:0] a, input logic [31:0] b,
                    input logic [31:0] exp_res, input logic [3:0] exp_fl, input string tag);
    @(negedge clk);
    if (bf) begin
      v16 = 1'b1; a16 = a[15:0]; b16 = b[15:0];
    end else begin
      v32 = 1'b1; a32 = a; b32 = b;
    end
    #1 check({tag, " ready_o"}, 32'(bf ? ro16 : ro32), 32'd1);
    @(posedge clk);
    @(negedge clk);
    v16 = 1'b0;
    v32 = 1'b0;
    check({tag, " lat1 valid_o"}, 32'(bf ? vo16 : vo32), 32'd0);
    @(negedge clk);
    check({tag, " lat2 valid_o"}, 32'(bf ? vo16 : vo32), 32'd0);
    @(negedge clk);
    check({tag, " lat3 valid_o"}, 32'(bf ? vo16 : vo32), 32'd1);
    check({tag, " result"}, bf ? {16'h0, res16} : res32, exp_res);
    check({tag, " flags"}, 32'(bf ? fl16 : fl32), 32'(exp_fl));
  endtask

  logic [31:0] st_a [8] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                            32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000};
  logic [31:0] st_e [8] = '{32'h40000000, 32'h40800000, 32'h40C00000, 32'h41000000,
                            32'h41200000, 32'h41400000, 32'h41600000, 32'h41800000};

  initial begin
    int          sent;
    int          recv;
    logic        held_valid;
    logic [31:0] held;
    bit          saw_stall;

    // Reset state
    #3;
    check("rst valid_o", 32'(vo32), 32'd0);
    check("rst result_o", res32, 32'd0);
    check("rst flags_o", 32'(fl32), 32'd0);
    check("rst ready_o", 32'(ro32), 32'd1);
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;

    // FP32 main function and exceptions
    op(1'b0, 32'h3F800000, 32'h3F800000, 32'h3F800000, 4'b0000, "one_x_one");
    op(1'b0, 32'h40000000, 32'h40400000, 32'h40C00000, 4'b0000, "two_x_three");
    op(1'b0, 32'h3F800001, 32'h3F800001, 32'h3F800002, 4'b0001, "rne_down");
    op(1'b0, 32'h3FC00001, 32'h3FC00001, 32'h40100002, 4'b0001, "rne_up");
    op(1'b0, 32'h2317A4DB, 32'h00000000, 32'h00000000, 4'b0000, "x_zero");
    op(1'b0, 32'h7F800000, 32'h00000000, 32'h7FC00000, 4'b1000, "inf_x_zero");
    op(1'b0, 32'h7FC00000, 32'h3F800000, 32'h7FC00000, 4'b0000, "qnan");
    op(1'b0, 32'h7F800001, 32'h3F800000, 32'h7FC00000, 4'b1000, "snan");
    op(1'b0, 32'h7F000000, 32'h40000000, 32'h7F800000, 4'b0101, "overflow");
    op(1'b0, 32'h00800000, 32'h3F000000, 32'h00000000, 4'b0011, "underflow");
    op(1'b0, 32'hFF800000, 32'h40000000, 32'hFF800000, 4'b0000, "neg_inf");

    // BF16 instance
    op(1'b1, 32'h3F80, 32'h4040, 32'h4040, 4'b0000, "bf16_1x3");
    op(1'b1, 32'h4000, 32'h4040, 32'h40C0, 4'b0000, "bf16_2x3");

    // Streaming with backpressure
    sent = 0;
    recv = 0;
    held_valid = 1'b0;
    held = '0;
    saw_stall = 1'b0;
    for (int cyc = 0; cyc < 40 && recv < 8; cyc++) begin
      @(negedge clk);
      if (held_valid) check("stream hold", res32, held);
      v32 = (sent < 8);
      if (sent < 8) a32 = st_a[sent];
      b32 = 32'h40000000;
      r32 = !(cyc >= 4 && cyc <= 7);
      #1;
      if (!ro32) saw_stall = 1'b1;
      if (vo32 && r32) begin
        check("stream data", res32, st_e[recv]);
        recv++;
      end
      held_valid = vo32 && !r32;
      held = res32;
      if (v32 && ro32) sent++;
    end
    v32 = 1'b0;
    r32 = 1'b1;
    check("stream count", 32'(recv), 32'd8);
    check("stream ready_o dropped", 32'(saw_stall), 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("stream no extra", 32'(vo32), 32'd0);
    end

    // Reset mid-flight
    @(negedge clk);
    v32 = 1'b1; a32 = 32'h3F800000; b32 = 32'h40000000;
    @(negedge clk);
    a32 = 32'h40400000;
    @(negedge clk);
    v32 = 1'b0;
    @(negedge clk);
    check("pre-reset valid_o", 32'(vo32), 32'd1);
    rstn = 1'b0;
    #1;
    check("reset valid_o", 32'(vo32), 32'd0);
    check("reset flags_o", 32'(fl32), 32'd0);
    rstn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("post-reset idle", 32'(vo32), 32'd0);
    end
    op(1'b0, 32'h40000000, 32'h40400000, 32'h40C00000, 4'b0000, "after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
